// File: rtl/counter_pkg.sv
// Shared types and helpers for the BCD counter slice.
// Converter state encoding and digit-count helper.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    // Decimal digits needed to show every value up to max.
    function automatic int bcd_digits(
        input longint unsigned max
    );
        int n;
        longint unsigned p;
        n = 1;
        p = 10;
        while ((p <= max) && (n < 20)) begin
            n++;
            p = p * 10;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter.
// Ports: clk, rst (async low), start/din in, busy/done/dout out.
module bin2bcd_seq
    import counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      din,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   dout
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    conv_state_t   state, state_n;
    logic [SW-1:0] sr, sr_n, adj;
    logic [CW-1:0] it, it_n;
    logic [BW-1:0] dout_n;
    logic          busy_n, done_n;

    // BCD half sits above the binary half in sr.
    always_comb begin
        adj = sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr[WIDTH+4*i +: 4] >= 4'd5) begin
                adj[WIDTH+4*i +: 4] =
                    sr[WIDTH+4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_n = state;
        sr_n    = sr;
        it_n    = it;
        dout_n  = dout;
        busy_n  = busy;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    sr_n    = {{BW{1'b0}}, din};
                    it_n    = '0;
                    busy_n  = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                sr_n = {adj[SW-2:0], 1'b0};
                it_n = it + 1'b1;
                if (it == CW'(WIDTH - 1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                dout_n  = sr[SW-1 -: BW];
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sr    <= '0;
            it    <= '0;
            dout  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            sr    <= sr_n;
            it    <= it_n;
            dout  <= dout_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

endmodule

// File: rtl/counter_bcd_seq.sv
// Up/down counter with preload and wrap modulus feeding a
// multi-cycle BCD converter. Ports: clk, rst (async low),
// en, dir, ld, v in; count, bcd, busy, done out.
module counter_bcd_seq
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DIGITS    = 3,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                dir,
    input  logic                ld,
    input  logic [WIDTH-1:0]    v,
    output logic [WIDTH-1:0]    count,
    output logic [4*DIGITS-1:0] bcd,
    output logic                busy,
    output logic                done
);

    if (bcd_digits(MAX_COUNT) > DIGITS) begin : g_chk
        $fatal(1, "DIGITS too small for MAX_COUNT");
    end

    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] last_conv;
    logic             start;

    always_comb begin
        count_n = count;
        if (ld) begin
            count_n = (v > MAX_COUNT) ? MAX_COUNT : v;
        end else if (en) begin
            if (!dir) begin
                count_n = (count == MAX_COUNT) ?
                          '0 : count + 1'b1;
            end else begin
                count_n = (count == '0) ?
                          MAX_COUNT : count - 1'b1;
            end
        end
    end

    // Converter is idle exactly when busy is low.
    assign start = (count != last_conv) && !busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            last_conv <= '0;
        end else begin
            count <= count_n;
            if (start) begin
                last_conv <= count;
            end
        end
    end

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (count),
        .busy  (busy),
        .done  (done),
        .dout  (bcd)
    );

endmodule

// File: doc/counter_bcd_seq.md
Name: counter_bcd_seq

Overview:
Parametrised up/down counter with synchronous preload and a programmable wrap modulus, plus a multi-cycle (iterative double-dabble) binary-to-BCD converter. Replaces the fixed 8-bit counter and combinational decoder pairing for wide counts, where a combinational decoder does not meet timing. Output drives the 7-segment/display path. BCD output is registered and updated with a done pulse.

Parameters:
WIDTH, 8, counter width in bits.
DIGITS, 3, number of BCD digits; 10**DIGITS > MAX_COUNT is checked at elaboration (fatal if violated).
MAX_COUNT, 2**WIDTH-1, largest count value; counter wraps modulo MAX_COUNT+1.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low: clears all state while rst==0.
en  input  1  count enable.
dir  input  1  0 = count up, 1 = count down.
ld  input  1  synchronous preload strobe.
v  input  WIDTH  preload value.
count  output  WIDTH  current binary count (registered).
bcd  output  4*DIGITS  last converted BCD value, digit 0 in bits [3:0].
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse on the edge that writes bcd.

Behaviour:
- Reset (rst==0): count=0, bcd=0, busy=0, done=0, last-converted register=0, FSM=IDLE. Reset may arrive at any point, including mid-conversion; the partial result is discarded. No conversion starts on the first edge after release, because count equals last-converted.
- Counter, evaluated per edge. Priority: ld > en.
  - ld=1: count <= min(v, MAX_COUNT). Values of v above MAX_COUNT clamp to MAX_COUNT.
  - ld=0, en=1, dir=0: count <= (count==MAX_COUNT) ? 0 : count+1.
  - ld=0, en=1, dir=1: count <= (count==0) ? MAX_COUNT : count-1.
  - Otherwise count holds.
- The counter runs independently of the converter and never stalls.
- Converter FSM, states IDLE, SHIFT, DONE:
  - IDLE: if count != last_conv, snapshot count into the shift register (BCD half zeroed), set last_conv=count, iteration counter=0, busy<=1, go to SHIFT. Otherwise stay.
  - SHIFT: each edge, add 3 to every BCD nibble >=5, then shift the whole {bcd, bin} register left by 1. After WIDTH shifts, go to DONE.
  - DONE: bcd <= BCD half, done<=1 for this cycle only, busy<=0, go to IDLE.
- Latency: a count change visible at cycle t produces updated bcd and done after the edge t+WIDTH+2.
- Count changes during a conversion do not disturb it. The newest count is picked up on the first IDLE cycle after DONE, so with continuous counting bcd refreshes every WIDTH+2 cycles.
- bcd holds its value between done pulses.
- Loading a value equal to last_conv triggers no conversion.
- Iteration counter width: $clog2(WIDTH+1).

Decomposition:
- Package counter_pkg holds:
  - the conv_state_t enum (IDLE, SHIFT, DONE);
  - a constant function bcd_digits(max) that returns the digit count needed for max, used in the elaboration check.
- Natural sub-module: bin2bcd_seq. It holds the iterative double-dabble FSM with a start/busy/done handshake, taking a WIDTH-bit input and producing 4*DIGITS-bit output.
- counter_bcd_seq instantiates the counter logic and bin2bcd_seq, and holds the last_conv compare that generates start.

Test Plan:
- Reset: pull rst low during SHIFT. Required: count=0, bcd=0, busy=0, done=0 asynchronously. After release with en=0 for 20 cycles: busy stays 0 and no done pulse.
- Default params, ld=1, v=255. Required: count=255 next edge; exactly one done pulse 10 edges later; bcd=12'h255; busy high for the 9 preceding cycles.
- MAX_COUNT=199:
  - count up from 199 -> 0;
  - dir=1 from 0 -> 199;
  - ld with v=250 -> count=199, then bcd=12'h199.
- ld=1, en=1, dir=0, v=42 in the same cycle. Required: count=42 (load wins, no increment); bcd=12'h042.
- en=1, dir=0 held from 0 for 50 cycles. Required: every done pulse shows a bcd equal to the BCD of the count snapshotted WIDTH+2 edges earlier; done spacing is exactly 10 cycles.
- WIDTH=12, DIGITS=4, ld with v=4095. Required: bcd=16'h4095 with done 14 edges after count updates.
